// File: rtl/record_demux_1_to_8.sv
// ============================================================================
// record_demux_1_to_8 : routes one record stream to 8 lanes with per-lane FIFOs
// Revision: 1.0
// ============================================================================
`default_nettype none

module record_demux_1_to_8 #(
  parameter int RECORD_DATA_WIDTH = 32,
  parameter int LANE_DEPTH        = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [RECORD_DATA_WIDTH-1:0]   i_data,
  input  logic [2:0]                     i_sel,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [8*RECORD_DATA_WIDTH-1:0] o_data,
  output logic [7:0]                     o_valid,
  input  logic [7:0]                     i_ready,
  output logic                           o_idle
);

  localparam int                 c_PTR_W = $clog2(LANE_DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(LANE_DEPTH);

  logic [7:0] w_full;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [RECORD_DATA_WIDTH-1:0] r_mem [LANE_DEPTH];
    logic [c_PTR_W-1:0]           r_wr_ptr;
    logic [c_PTR_W-1:0]           r_rd_ptr;
    logic [c_CNT_W-1:0]           r_count;
    logic                         w_push;
    logic                         w_pop;

    // Full test uses the registered count only, so a same-cycle pop never frees a slot
    assign w_push = i_valid && (i_sel == 3'(k)) && (r_count != c_FULL);
    assign w_pop  = (r_count != '0) && i_ready[k];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int e = 0; e < LANE_DEPTH; e++) begin
          r_mem[e] <= '0;
        end
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= i_data;
          r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    assign w_full[k]                                   = (r_count == c_FULL);
    assign o_valid[k]                                  = (r_count != '0);
    assign o_data[k*RECORD_DATA_WIDTH +: RECORD_DATA_WIDTH] = r_mem[r_rd_ptr];
  end

  assign o_ready = ~w_full[i_sel];
  assign o_idle  = ~|o_valid;

endmodule

`default_nettype wire

// File: tb/tb_record_demux_1_to_8.sv
// ============================================================================
// tb_record_demux_1_to_8 : self-checking bench with per-lane queue reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_record_demux_1_to_8;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [W-1:0]   i_data;
  logic [2:0]     i_sel;
  logic           i_valid;
  logic           o_ready;
  logic [8*W-1:0] o_data;
  logic [7:0]     o_valid;
  logic [7:0]     i_ready;
  logic           o_idle;

  always #20 i_clk = ~i_clk;

  record_demux_1_to_8 #(
    .RECORD_DATA_WIDTH (W),
    .LANE_DEPTH        (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_sel   (i_sel),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_idle  (o_idle)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] q [8][$];
  int           recv [8];
  logic         stall_prev;
  logic [2:0]   prev_sel;

  typedef struct {
    logic         valid;
    logic [2:0]   sel;
    logic [W-1:0] data;
    logic [7:0]   ready;
    logic         exp_ready;
    logic [7:0]   exp_valid;
    logic         exp_idle;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d, input logic [7:0] r);
    i_valid = v;
    i_sel   = s;
    i_data  = d;
    i_ready = r;
  endtask

  function automatic logic model_idle();
    for (int k = 0; k < 8; k++) begin
      if (q[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Compare every DUT output with the queue model, away from the active edge
  task automatic sample_and_check();
    @(negedge i_clk);
    if (stall_prev && i_valid) begin
      n_tests++;
      if (i_sel !== prev_sel) begin
        n_fail++;
        $display("FAIL proto_sel_hold: got %0d, expected %0d", i_sel, prev_sel);
      end
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("valid_l%0d", k), o_valid[k], q[k].size() != 0);
      if (q[k].size() != 0)
        chk($sformatf("data_l%0d", k), o_data[k*W +: W], q[k][0]);
    end
    chk("ready", o_ready, q[i_sel].size() < DEPTH);
    chk("idle", o_idle, model_idle());
    stall_prev = i_valid && !o_ready;
    prev_sel   = i_sel;
  endtask

  // Apply the cycle's transfers to the model across the next rising edge
  task automatic advance();
    logic         r;
    logic         do_push;
    logic [7:0]   do_pop;
    logic [2:0]   s;
    logic [W-1:0] d;
    r       = i_rst;
    s       = i_sel;
    d       = i_data;
    do_push = i_valid && (q[s].size() < DEPTH);
    for (int k = 0; k < 8; k++) do_pop[k] = (q[k].size() != 0) && i_ready[k];
    @(posedge i_clk);
    if (!r) begin
      for (int k = 0; k < 8; k++) begin
        if (do_pop[k]) begin
          void'(q[k].pop_front());
          recv[k]++;
        end
      end
      if (do_push) q[s].push_back(d);
    end
    #1;
  endtask

  initial begin
    int idx;
    int guard;

    i_rst      = 1'b1;
    stall_prev = 1'b0;
    prev_sel   = '0;
    drive(1'b0, 3'd0, '0, 8'h00);
    for (int k = 0; k < 8; k++) recv[k] = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 8'h00);
    chk("rst_idle", o_idle, 1'b1);
    chk("rst_data", o_data, '0);
    chk("rst_ready", o_ready, 1'b1);
    i_rst = 1'b0;

    // Lane 2 back-pressure, lane 6 bypasses it, full-and-pop refusal, then drain
    vecs[0]  = '{1'b1, 3'd2, 32'h11, 8'hBB, 1'b1, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 3'd2, 32'h22, 8'hBB, 1'b1, 8'h04, 1'b0};
    vecs[2]  = '{1'b1, 3'd6, 32'h44, 8'hBB, 1'b1, 8'h04, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 32'h33, 8'hBB, 1'b0, 8'h44, 1'b0};
    vecs[4]  = '{1'b1, 3'd2, 32'h33, 8'hBB, 1'b0, 8'h44, 1'b0};
    vecs[5]  = '{1'b1, 3'd2, 32'h33, 8'hFF, 1'b0, 8'h44, 1'b0};
    vecs[6]  = '{1'b1, 3'd2, 32'h33, 8'hBB, 1'b1, 8'h04, 1'b0};
    vecs[7]  = '{1'b0, 3'd2, 32'h00, 8'hBB, 1'b0, 8'h04, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 32'h00, 8'hFF, 1'b1, 8'h04, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 32'h00, 8'hFF, 1'b1, 8'h04, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 32'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ready);
      sample_and_check();
      chk($sformatf("vec%0d_ready", i), o_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_idle", i), o_idle, vecs[i].exp_idle);
      advance();
    end

    // Single route with one-cycle latency
    drive(1'b1, 3'd5, 32'hDEADBEEF, 8'hFF);
    sample_and_check();
    advance();
    drive(1'b0, 3'd0, '0, 8'hFF);
    sample_and_check();
    chk("route_valid", o_valid, 8'h20);
    chk("route_data", o_data[5*W +: W], 32'hDEADBEEF);
    advance();
    sample_and_check();
    chk("route_valid_after", o_valid, 8'h00);
    chk("route_idle_after", o_idle, 1'b1);
    advance();

    // Reset mid-stream with lane 3 holding two records
    drive(1'b1, 3'd3, 32'hA1, 8'h00); sample_and_check(); advance();
    drive(1'b1, 3'd3, 32'hA2, 8'h00); sample_and_check(); advance();
    drive(1'b1, 3'd1, 32'hA3, 8'h00); sample_and_check(); advance();
    i_rst = 1'b1;
    for (int k = 0; k < 8; k++) q[k].delete();
    stall_prev = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 8'h00);
    chk("midrst_idle", o_idle, 1'b1);
    chk("midrst_data", o_data, '0);
    for (int s = 0; s < 8; s++) begin
      i_sel = 3'(s);
      #1;
      chk($sformatf("midrst_ready_sel%0d", s), o_ready, 1'b1);
    end
    drive(1'b1, 3'd3, 32'hB1, 8'hFF);
    sample_and_check();
    advance();
    i_rst = 1'b0;
    drive(1'b0, 3'd0, '0, 8'hFF);
    sample_and_check();
    chk("postrst_valid", o_valid, 8'h00);
    advance();

    // Round robin: 64 records, random consumer readiness
    for (int k = 0; k < 8; k++) recv[k] = 0;
    idx   = 0;
    guard = 0;
    while ((idx < 64 || stall_prev) && guard < 3000) begin
      if (!stall_prev) begin
        i_valid = 1'b1;
        i_sel   = 3'(idx % 8);
        i_data  = $urandom;
        idx++;
      end
      i_ready = 8'($urandom);
      sample_and_check();
      advance();
      guard++;
    end
    chk("rr_guard", guard < 3000, 1'b1);
    drive(1'b0, 3'd0, '0, 8'hFF);
    guard = 0;
    while (!model_idle() && guard < 20) begin
      sample_and_check();
      advance();
      guard++;
    end
    sample_and_check();
    advance();
    for (int k = 0; k < 8; k++) chk($sformatf("rr_count_l%0d", k), recv[k], 8);

    // Fill every lane, then drain all in parallel
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'(i % 8), $urandom, 8'h00);
      sample_and_check();
      advance();
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    sample_and_check();
    chk("fill_valid", o_valid, 8'hFF);
    advance();
    sample_and_check();
    advance();
    sample_and_check();
    chk("drain_idle", o_idle, 1'b1);
    chk("drain_valid", o_valid, 8'h00);
    advance();

    // Free-running random traffic
    repeat (400) begin
      if (!stall_prev) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_sel   = 3'($urandom);
        i_data  = $urandom;
      end
      i_ready = 8'($urandom);
      sample_and_check();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/record_demux_1_to_8.md
# record_demux_1_to_8

Routes a single record stream into one of eight output lanes chosen per record by a 3-bit lane index, with a small FIFO per lane so that back-pressure on one lane does not stall records headed elsewhere once they are buffered. It is the distribution counterpart of the 8-to-1 record selection path: it feeds per-leaf record streams into the merge tree inputs and is fed by the record loader. Records are forwarded unmodified, and per-lane order is preserved.

## Interface
- RECORD_DATA_WIDTH, default 32: width of one record in bits.
- LANE_DEPTH, default 2: entries per lane FIFO; must be a power of two and ≥ 2.
- i_clk  input  1  sole clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_data  input  RECORD_DATA_WIDTH  incoming record.
- i_sel  input  3  destination lane index, 0..7.
- i_valid  input  1  i_data/i_sel valid.
- o_ready  output  1  demux can accept the record addressed by i_sel this cycle.
- o_data  output  8*RECORD_DATA_WIDTH  lane k head record at bits [k*W +: W].
- o_valid  output  8  bit k: lane k head valid.
- i_ready  input  8  bit k: lane k consumer accepts the head.
- o_idle  output  1  all eight lanes empty.

## Operation
- Per lane: storage array of LANE_DEPTH records, write pointer, read pointer, and occupancy count 0..LANE_DEPTH. Pointers are log2(LANE_DEPTH) bits wide and wrap modulo LANE_DEPTH. The count is log2(LANE_DEPTH)+1 bits wide.
- o_ready = (count[i_sel] != LANE_DEPTH). This is combinational from i_sel and registered counts only, with no path from i_ready.
- Push: when i_valid && o_ready, write i_data to lane i_sel at its write pointer, then advance that pointer.
- Upstream holds i_data/i_sel stable while i_valid && !o_ready. Changing i_sel under stall is a protocol violation, and the bench flags it.
- o_valid[k] = (count[k] != 0). Lane k o_data is the storage entry at read pointer k.
- Pop: when o_valid[k] && i_ready[k], advance read pointer k.
- Count update per lane: push only gives +1, pop only gives −1, push and pop together give unchanged.
- All eight lanes may pop in the same cycle, alongside at most one push.
- Full lane: a push is refused even if the same lane pops that cycle. o_ready is not relieved by a same-cycle pop.
- Empty lane: no pop is possible, because o_valid is 0. A record pushed into an empty lane is not visible in the same cycle (no bypass).
- o_idle = all counts zero. It is registered-derived and combinational from the counts.
- Out-of-range is impossible because i_sel is 3 bits. The lane count is fixed at 8.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - All pointers and counts are cleared to 0. Storage is cleared to 0.
  - o_valid = 8'h00, o_data = 0, o_idle = 1, and o_ready = 1 for any i_sel.
- Reset mid-operation discards all buffered records immediately, with no drain. A push or pop in the reset cycle has no effect.
- Latency: a record accepted on edge N appears with o_valid high after edge N, so it is presentable in cycle N+1.
- Throughput: one record per cycle into any lane, provided the target lane is not full.
- A lane that is full and popped every cycle sustains 1 record per cycle only for LANE_DEPTH ≥ 2 with alternating fill. With LANE_DEPTH=2 and a continuously ready consumer, a single lane sustains 1 record per cycle.
- o_data[k] and o_valid[k] are stable while o_valid[k] && !i_ready[k].

## Test plan
- Reset: assert i_rst mid-stream with lane 3 holding 2 records -> o_valid=0x00, o_idle=1, o_ready=1 immediately. After release, no stale record appears.
- Single route: push 0xDEADBEEF with i_sel=5, i_ready=0xFF -> next cycle o_valid=0x20, lane 5 data 0xDEADBEEF. One cycle later o_valid=0x00 and o_idle=1.
- Full lane back-pressure (LANE_DEPTH=2): i_ready[2]=0, push 0x11, 0x22, 0x33 to lane 2 -> o_ready=0 on the third push, and 0x33 is held.
  - Meanwhile, a push of 0x44 to lane 6 is accepted.
  - Raise i_ready[2] -> lane 2 emits 0x11, 0x22, 0x33 in order.
- Full-and-pop same cycle: lane 2 full, i_ready[2]=1, push to lane 2 -> o_ready=0 that cycle. The push is accepted next cycle, and the count goes to 2.
- Round robin: 64 records with i_sel cycling 0..7, random i_ready -> each lane receives exactly its 8 records in order, with no loss or duplication. Scoreboard per lane.
- Simultaneous pops: fill all 8 lanes, then drive i_ready=0xFF for 2 cycles -> all lanes drain in parallel, and o_idle=1 after the second cycle.
